// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor: word/field widths, instruction
// field positions, the opcode and timestep enumerations, and a small decode
// helper. The controller, ALU and register file all import this package.
package proc_pkg;

  localparam int DATA_W = 10;
  localparam int RA_W   = 2;
  localparam int OP_W   = 4;

  // Instruction field positions: IR[9:8]=Rx, IR[7:6]=Ry, IR[5:4] reserved, IR[3:0]=opcode
  localparam int RX_HI = 9;
  localparam int RX_LO = 8;
  localparam int RY_HI = 7;
  localparam int RY_LO = 6;
  localparam int OP_HI = 3;
  localparam int OP_LO = 0;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 4'b0000,
    OP_COPY = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_INV  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  // True for opcodes that take the three-step ALU path (ADD..XOR).
  // Opcodes 1000..1111 are illegal and never count as ALU ops.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= 4'd2) && (op <= 4'd7);
  endfunction

endpackage

// File: rtl/timestep_counter.sv
// Two-bit T0..T3 timestep counter for the instruction sequencer.
// Ports:
//   clk     - clock, falling-edge active (shared with the register file)
//   clear   - synchronous clear to T0; wins over advance
//   advance - step to the next timestep
//   tstep   - current timestep (this is the sequencer's state register)
module timestep_counter
  import proc_pkg::*;
(
  input  logic   clk,
  input  logic   clear,
  input  logic   advance,
  output tstep_e tstep
);

  logic [1:0] count;

  always_ff @(negedge clk) begin
    if (clear) begin
      count <= 2'd0;
    end else if (advance) begin
      count <= count + 2'd1;
    end
  end

  assign tstep = tstep_e'(count);

endmodule

// File: rtl/controller_fsm.sv
// Instruction sequencer for the 10-bit processor. Latches one instruction
// word when Exec is seen in T0, then walks T1..T3 driving the register-file
// and ALU/bus controls for that instruction. Pulses Done on retirement.
//
// Handshake: Exec is a level request sampled only in T0 on the active
// (falling) edge; when sampled high, Instr is captured into IR in the same
// edge. Exec and Instr are ignored in T1..T3, so IR is stable for the whole
// instruction. Holding Exec high issues back-to-back instructions with one
// T0 cycle between them.
//
// Ports:
//   CLKb     - clock, falling-edge active
//   Rst      - synchronous active-high reset; aborts any instruction
//   Exec     - start request
//   Instr    - instruction word, captured on accepted Exec
//   IR       - latched instruction (debug/display)
//   ENW/WRA  - register-file write enable / address
//   ENR0/RDA0- read port 0 enable / address
//   ENR1/RDA1- read port 1 (reserved, held 0)
//   Ain/Gin  - load ALU A register / result register G
//   Gout/Ext - G or external word drives the bus
//   ALUcont  - ALU operation select
//   Done     - one-cycle retirement pulse
//   Busy     - high in T1..T3 (state observation)
module controller_fsm
  import proc_pkg::*;
(
  input  logic              CLKb,
  input  logic              Rst,
  input  logic              Exec,
  input  logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] IR,
  output logic              ENW,
  output logic [RA_W-1:0]   WRA,
  output logic              ENR0,
  output logic [RA_W-1:0]   RDA0,
  output logic              ENR1,
  output logic [RA_W-1:0]   RDA1,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              Ext,
  output logic [OP_W-1:0]   ALUcont,
  output logic              Done,
  output logic              Busy
);

  tstep_e            tstep;
  logic              clear;
  logic              advance;
  logic [DATA_W-1:0] ir_q;
  logic [RA_W-1:0]   rx;
  logic [RA_W-1:0]   ry;
  logic [OP_W-1:0]   opc;

  // State register: the timestep counter holds the FSM state.
  timestep_counter u_tstep (
    .clk     (CLKb),
    .clear   (clear),
    .advance (advance),
    .tstep   (tstep)
  );

  // Instruction register: loads only on an accepted Exec in T0.
  always_ff @(negedge CLKb) begin
    if (Rst) begin
      ir_q <= '0;
    end else if ((tstep == T0) && Exec) begin
      ir_q <= Instr;
    end
  end

  assign IR  = ir_q;
  assign rx  = ir_q[RX_HI:RX_LO];
  assign ry  = ir_q[RY_HI:RY_LO];
  assign opc = ir_q[OP_HI:OP_LO];

  // Read port 1 is reserved in this revision.
  assign ENR1 = 1'b0;
  assign RDA1 = '0;
  assign Busy = (tstep != T0);

  // Next-state control and output decode. Only one of ENR0/Gout/Ext is
  // ever set in a given timestep, so the bus never has two drivers.
  always_comb begin
    clear   = 1'b0;
    advance = 1'b0;
    ENW     = 1'b0;
    WRA     = '0;
    ENR0    = 1'b0;
    RDA0    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    Ext     = 1'b0;
    ALUcont = '0;
    Done    = 1'b0;

    case (tstep)
      T0: begin
        advance = Exec;
      end
      T1: begin
        if (opc == OP_LOAD) begin
          Ext   = 1'b1;
          ENW   = 1'b1;
          WRA   = rx;
          Done  = 1'b1;
          clear = 1'b1;
        end else if (opc == OP_COPY) begin
          ENR0  = 1'b1;
          RDA0  = ry;
          ENW   = 1'b1;
          WRA   = rx;
          Done  = 1'b1;
          clear = 1'b1;
        end else if (is_alu_op(opc)) begin
          ENR0    = 1'b1;
          RDA0    = rx;
          Ain     = 1'b1;
          advance = 1'b1;
        end else begin
          // Illegal opcode retires as a NOP.
          Done  = 1'b1;
          clear = 1'b1;
        end
      end
      T2: begin
        ENR0    = 1'b1;
        RDA0    = ry;
        Gin     = 1'b1;
        ALUcont = opc;
        advance = 1'b1;
      end
      T3: begin
        Gout  = 1'b1;
        ENW   = 1'b1;
        WRA   = rx;
        Done  = 1'b1;
        clear = 1'b1;
      end
      default: begin
        clear = 1'b1;
      end
    endcase

    // Reset aborts mid-instruction; the counter drops straight to T0.
    if (Rst) begin
      clear = 1'b1;
    end
  end

endmodule

// File: tb/tb_controller_fsm.sv
module tb_controller_fsm;

  localparam int W = 29;

  logic       CLKb;
  logic       Rst;
  logic       Exec;
  logic [9:0] Instr;
  logic [9:0] IR;
  logic       ENW, ENR0, ENR1, Ain, Gin, Gout, Ext, Done, Busy;
  logic [1:0] WRA, RDA0, RDA1;
  logic [3:0] ALUcont;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           failures;

  // bench-side model state for the random section
  int         mt;
  logic [9:0] mir;

  controller_fsm dut (
    .CLKb    (CLKb),
    .Rst     (Rst),
    .Exec    (Exec),
    .Instr   (Instr),
    .IR      (IR),
    .ENW     (ENW),
    .WRA     (WRA),
    .ENR0    (ENR0),
    .RDA0    (RDA0),
    .ENR1    (ENR1),
    .RDA1    (RDA1),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .Ext     (Ext),
    .ALUcont (ALUcont),
    .Done    (Done),
    .Busy    (Busy)
  );

  // clock / reset
  initial begin
    CLKb = 1'b1;
    forever #5 CLKb = ~CLKb;
  end

  // Expected output vector for timestep t with instruction ir.
  function automatic logic [W-1:0] exp_vec(input int t, input logic [9:0] ir);
    logic       enw, enr0, ain, gin, gout, ext, done, busy;
    logic [1:0] wra, rda0, rx, ry;
    logic [3:0] aluc, op;
    enw = 0; enr0 = 0; ain = 0; gin = 0; gout = 0; ext = 0; done = 0;
    wra = 0; rda0 = 0; aluc = 0;
    op = ir[3:0]; rx = ir[9:8]; ry = ir[7:6];
    busy = (t != 0);
    case (t)
      1: begin
        if (op == 4'd0) begin
          ext = 1; enw = 1; wra = rx; done = 1;
        end else if (op == 4'd1) begin
          enr0 = 1; rda0 = ry; enw = 1; wra = rx; done = 1;
        end else if (op < 4'd8) begin
          enr0 = 1; rda0 = rx; ain = 1;
        end else begin
          done = 1;
        end
      end
      2: begin
        enr0 = 1; rda0 = ry; gin = 1; aluc = op;
      end
      3: begin
        gout = 1; enw = 1; wra = rx; done = 1;
      end
      default: ;
    endcase
    return {ir, enw, wra, enr0, rda0, 1'b0, 2'b00, ain, gin, gout, ext, aluc, done, busy};
  endfunction

  task automatic push_exp(input string tag, input int t, input logic [9:0] ir);
    exp_q.push_back(exp_vec(t, ir));
    tag_q.push_back(tag);
  endtask

  // scoreboard: pop one expectation and compare, plus the bus-driver rule
  task automatic check_outputs();
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    string        tag;
    obs = {IR, ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, Ext, ALUcont, Done, Busy};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL queue_empty observed=%h expected=<entry>", obs);
    end else begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      assert (obs === expv) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
    end
    checks++;
    assert ($onehot0({ENR0, Gout, Ext})) else begin
      failures++;
      $error("FAIL bus_rule observed=%b expected=onehot0", {ENR0, Gout, Ext});
    end
  endtask

  // driver: apply inputs away from the active edge, then sample #1 after it
  task automatic drive_cycle(input logic exec, input logic [9:0] instr, input logic rst);
    Exec  = exec;
    Instr = instr;
    Rst   = rst;
    @(negedge CLKb);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       r_exec, r_rst;
    logic [9:0] r_instr;
    logic [3:0] op;
    checks = 0;
    failures = 0;
    Rst = 1'b1;
    Exec = 1'b0;
    Instr = '0;

    // reset held for two edges
    push_exp("reset0", 0, 10'h000); drive_cycle(0, 10'h000, 1);
    push_exp("reset1", 0, 10'h000); drive_cycle(0, 10'h000, 1);
    // idle with Exec low: Instr must be ignored, no Done
    push_exp("idle0", 0, 10'h000); drive_cycle(0, 10'(($urandom_range(0, 1023))), 0);
    push_exp("idle1", 0, 10'h000); drive_cycle(0, 10'h3FF, 0);

    // LOAD R2
    push_exp("load_t1", 1, 10'h200); drive_cycle(1, 10'h200, 0);
    push_exp("load_t0", 0, 10'h200); drive_cycle(0, 10'h000, 0);

    // ADD R1, R3
    push_exp("add_t1", 1, 10'h1C2); drive_cycle(1, 10'h1C2, 0);
    push_exp("add_t2", 2, 10'h1C2); drive_cycle(0, 10'h000, 0);
    push_exp("add_t3", 3, 10'h1C2); drive_cycle(0, 10'h000, 0);
    push_exp("add_t0", 0, 10'h1C2); drive_cycle(0, 10'h000, 0);

    // illegal opcode retires as NOP
    push_exp("ill_t1", 1, 10'h00F); drive_cycle(1, 10'h00F, 0);
    push_exp("ill_t0", 0, 10'h00F); drive_cycle(0, 10'h000, 0);

    // SUB R2, R1 aborted by reset in T2
    push_exp("sub_t1", 1, 10'h243); drive_cycle(1, 10'h243, 0);
    push_exp("sub_t2", 2, 10'h243); drive_cycle(0, 10'h000, 0);
    push_exp("sub_rst", 0, 10'h000); drive_cycle(0, 10'h000, 1);
    push_exp("sub_after", 0, 10'h000); drive_cycle(0, 10'h000, 0);

    // XOR R3, R0 with Exec raised in T1 and T2 with a different word
    push_exp("xor_t1", 1, 10'h307); drive_cycle(1, 10'h307, 0);
    push_exp("xor_t2", 2, 10'h307); drive_cycle(1, 10'h0A5, 0);
    push_exp("xor_t3", 3, 10'h307); drive_cycle(1, 10'h0A5, 0);
    push_exp("xor_t0", 0, 10'h307); drive_cycle(0, 10'h000, 0);

    // Exec held high: COPY R1<-R2 then AND R0,R3 with one T0 between
    push_exp("b2b_copy_t1", 1, 10'h181); drive_cycle(1, 10'h181, 0);
    push_exp("b2b_copy_t0", 0, 10'h181); drive_cycle(1, 10'h0C5, 0);
    push_exp("b2b_and_t1", 1, 10'h0C5); drive_cycle(1, 10'h0C5, 0);
    push_exp("b2b_and_t2", 2, 10'h0C5); drive_cycle(1, 10'h0C5, 0);
    push_exp("b2b_and_t3", 3, 10'h0C5); drive_cycle(1, 10'h0C5, 0);
    push_exp("b2b_and_t0", 0, 10'h0C5); drive_cycle(0, 10'h000, 0);

    // random stimulus against the bench timestep model
    mt  = 0;
    mir = 10'h0C5;
    for (int i = 0; i < 120; i++) begin
      r_exec  = ($urandom_range(0, 2) != 0);
      r_instr = 10'($urandom_range(0, 1023));
      r_rst   = ($urandom_range(0, 15) == 0);
      if (r_rst) begin
        mt  = 0;
        mir = 10'h000;
      end else begin
        case (mt)
          0: if (r_exec) begin mt = 1; mir = r_instr; end
          1: begin
            op = mir[3:0];
            mt = (op >= 4'd2 && op <= 4'd7) ? 2 : 0;
          end
          2: mt = 3;
          default: mt = 0;
        endcase
      end
      push_exp("random", mt, mir);
      drive_cycle(r_exec, r_instr, r_rst);
    end

    // every pushed expectation must have been consumed
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_fsm.md
Name: controller_fsm

Overview:
- Instruction sequencer for the 10-bit processor.
- Latches one instruction word, then steps through timesteps T0..T3.
- Each timestep drives the register-file control pins (ENW, ENR0, ENR1, WRA, RDA0, RDA1) and the ALU/bus controls (Ain, Gin, Gout, Ext, ALUcont).
- Sits directly upstream of the register file and ALU. Pulses Done when an instruction retires.

Parameters:
DATA_W, 10, instruction/data word width
RA_W, 2, register address width (4 registers)
OP_W, 4, opcode field width

Ports:
CLKb  in  1  clock; active edge is the falling edge, same as the register file
Rst  in  1  reset; synchronous, active-high
Exec  in  1  start request, level-sampled in T0
Instr  in  DATA_W  instruction word, sampled only when Exec is accepted
IR  out  DATA_W  latched instruction (debug/display)
ENW  out  1  register-file write enable
WRA  out  RA_W  register-file write address
ENR0  out  1  register-file read-port-0 enable
RDA0  out  RA_W  read-port-0 address
ENR1  out  1  read-port-1 enable; held 0 in this revision, reserved
RDA1  out  RA_W  read-port-1 address; held 0
Ain  out  1  load ALU A operand register from bus
Gin  out  1  load ALU result register G
Gout  out  1  G drives bus
Ext  out  1  external Instr/data word drives bus
ALUcont  out  OP_W  ALU operation select
Done  out  1  one-cycle pulse marking instruction retirement
Busy  out  1  high in T1..T3

Behaviour:
- Interface: one clock, CLKb. Reset Rst is synchronous and active-high. Rst is sampled on the active edge of CLKb.
- Instruction format:
  - IR[9:8] = Rx (destination / first operand)
  - IR[7:6] = Ry (source)
  - IR[5:4] = reserved, ignored
  - IR[3:0] = opcode
- Opcodes:
  - 0000 LOAD Rx <- external word
  - 0001 COPY Rx <- Ry
  - 0010 ADD Rx <- Rx + Ry
  - 0011 SUB Rx <- Rx - Ry
  - 0100 INV Rx <- ~Ry
  - 0101 AND
  - 0110 OR
  - 0111 XOR
  - 1000..1111 illegal; executed as NOP
- Arithmetic is mod 2^10; no flags.
- State: one-hot or binary encoding of T0, T1, T2, T3, plus registered IR. All outputs decode combinationally from state and IR. Every output not listed for a state is 0.
- Reset: state = T0, IR = 0. All outputs 0, including Done and Busy. Rst has priority over every other input, including mid-instruction. An aborted instruction performs no further writes.
- T0 (idle):
  - If Exec = 1 at the edge: IR <= Instr, go to T1.
  - Otherwise stay in T0.
  - Outputs all 0.
- T1 by opcode:
  - LOAD: Ext = 1, ENW = 1, WRA = Rx, Done = 1; next state T0.
  - COPY: ENR0 = 1, RDA0 = Ry, ENW = 1, WRA = Rx, Done = 1; next state T0.
  - ALU ops: ENR0 = 1, RDA0 = Rx, Ain = 1; next state T2.
  - Illegal: Done = 1 only; next state T0.
- T2 (ALU ops only): ENR0 = 1, RDA0 = Ry, Gin = 1, ALUcont = opcode; next state T3.
- T3 (ALU ops only): Gout = 1, ENW = 1, WRA = Rx, Done = 1; next state T0.
- Latency: LOAD, COPY and NOP finish 2 edges after Exec is accepted; ALU ops finish 4 edges after.
- Exec:
  - Ignored in T1..T3; IR stays stable for the whole instruction.
  - Exec held high causes back-to-back instructions with one T0 cycle between them.
- Bus rule: at most one of {ENR0, Gout, Ext} is 1 in any state.
- Busy = (state != T0).

Decomposition:
- Shared package proc_pkg holds:
  - opcode enum op_e
  - timestep enum tstep_e
  - field-slice constants RX_HI/RX_LO, RY_HI/RY_LO, OP_HI/OP_LO
  - DATA_W
- The ALU and the register file import the same package.
- One sub-module, timestep_counter: 2-bit T0..T3 counter with synchronous clear and enable. The FSM drives its clear (on retire/Rst) and its advance.

Test Plan:
- Rst = 1 for 2 edges, then 0 -> every output 0, state T0, IR = 10'h000; Done never asserts while Exec = 0.
- Exec = 1 with Instr = 10'h200 (LOAD R2) -> next cycle: Ext = 1, ENW = 1, WRA = 2, Done = 1, Busy = 1; following cycle all 0.
- Instr = 10'h1C2 (ADD R1, R3) -> T1: RDA0 = 1, Ain = 1; T2: RDA0 = 3, Gin = 1, ALUcont = 4'b0010; T3: Gout = 1, ENW = 1, WRA = 1, Done = 1. Check that no two bus drivers are ever 1 together.
- Instr = 10'h00F (illegal) -> T1: Done = 1 only; ENW = 0 throughout.
- Start SUB, assert Rst = 1 in T2 -> next edge T0 with all outputs 0; ENW never 1 for that instruction.
- Exec toggled to 1 during T2 with a different Instr -> ignored; IR unchanged; the original instruction completes with WRA = original Rx.
